// File: rtl/regfile_pkg.sv
// Shared widths and enumerations for the register-file writeback arbiter.
package regfile_pkg;

  localparam int unsigned REG_ADDR = 5;
  localparam int unsigned REG_DATA = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; bit 0 is requester A, bit 1 is requester B.
module rr_arbiter2
  import regfile_pkg::req_id_e;
  import regfile_pkg::REQ_A;
  import regfile_pkg::REQ_B;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  req_id_e last_grant;

  // On a tie the requester not served most recently wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_grant == REQ_B) ? 2'b01 : 2'b10;
    end
  end

  // Reset to B so that A wins the very first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= REQ_B;
    end else if (accept) begin
      last_grant <= gnt[1] ? REQ_B : REQ_A;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Clears registers 1..2**REG_ADDR-1 after reset, then arbitrates ALU (A) and
// load (B) writebacks onto a single register-file write port.
module regfile_wb_arbiter
  import regfile_pkg::state_e;
  import regfile_pkg::CLEAR;
  import regfile_pkg::RUN;
#(
  parameter int unsigned REG_ADDR = regfile_pkg::REG_ADDR,
  parameter int unsigned REG_DATA = regfile_pkg::REG_DATA
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  input  logic [REG_ADDR-1:0] a_addr,
  input  logic [REG_DATA-1:0] a_data,
  output logic                a_ready,
  input  logic                b_valid,
  input  logic [REG_ADDR-1:0] b_addr,
  input  logic [REG_DATA-1:0] b_data,
  output logic                b_ready,
  output logic [REG_ADDR-1:0] reg_write,
  output logic [REG_DATA-1:0] reg_write_data,
  output logic                reg_write_control,
  output logic                init_done
);

  state_e              state;
  logic [REG_ADDR-1:0] clear_ptr;
  logic [1:0]          req;
  logic [1:0]          gnt;
  logic                accept;
  logic [REG_ADDR-1:0] sel_addr;
  logic [REG_DATA-1:0] sel_data;

  // Requests are only visible to the arbiter once clearing has finished.
  assign req    = {b_valid, a_valid} & {2{state == RUN}};
  assign accept = |gnt;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .accept (accept),
    .gnt    (gnt)
  );

  assign a_ready  = gnt[0];
  assign b_ready  = gnt[1];
  assign sel_addr = gnt[1] ? b_addr : a_addr;
  assign sel_data = gnt[1] ? b_data : a_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= CLEAR;
      clear_ptr         <= REG_ADDR'(1);
      reg_write         <= '0;
      reg_write_data    <= '0;
      reg_write_control <= 1'b0;
      init_done         <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          reg_write_control <= 1'b1;
          reg_write         <= clear_ptr;
          reg_write_data    <= '0;
          clear_ptr         <= clear_ptr + REG_ADDR'(1);
          if (clear_ptr == '1) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          // x0 is hardwired: the handshake completes but no write is issued.
          reg_write_control <= 1'b0;
          if (accept && (sel_addr != '0)) begin
            reg_write_control <= 1'b1;
            reg_write         <= sel_addr;
            reg_write_data    <= sel_data;
          end
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: clear sequence, table-driven arbitration with a write
// scoreboard, and reset-abort / request-during-clear sequences.
module tb_regfile_wb_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_valid = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_data = '0;
  logic          a_ready;
  logic          b_valid = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_data = '0;
  logic          b_ready;
  logic [AW-1:0] reg_write;
  logic [DW-1:0] reg_write_data;
  logic          reg_write_control;
  logic          init_done;

  regfile_wb_arbiter #(.REG_ADDR(AW), .REG_DATA(DW)) dut (
    .clk               (clk),
    .rst               (rst),
    .a_valid           (a_valid),
    .a_addr            (a_addr),
    .a_data            (a_data),
    .a_ready           (a_ready),
    .b_valid           (b_valid),
    .b_addr            (b_addr),
    .b_data            (b_data),
    .b_ready           (b_ready),
    .reg_write         (reg_write),
    .reg_write_data    (reg_write_data),
    .reg_write_control (reg_write_control),
    .init_done         (init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          av;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          bv;
    logic [AW-1:0] ba;
    logic [DW-1:0] bd;
    logic          exp_a_ready;
    logic          exp_b_ready;
  } vec_t;

  typedef struct {
    logic          ctrl;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          chk_payload;
  } wr_t;

  int            n_vec = 0;
  int            n_err = 0;
  vec_t          tbl[11];
  wr_t           sbq[$];
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ctrl", 32'(reg_write_control), 32'(0));
    chk("rst_addr", 32'(reg_write), 32'(0));
    chk("rst_data", reg_write_data, 32'(0));
    chk("rst_init_done", 32'(init_done), 32'(0));
    chk("rst_a_ready", 32'(a_ready), 32'(0));
    chk("rst_b_ready", 32'(b_ready), 32'(0));
  endtask

  // Runs n clear edges from a freshly released reset, checking each write.
  task automatic clear_seq(input int n);
    for (int i = 1; i <= n; i++) begin
      chk("clr_a_ready", 32'(a_ready), 32'(0));
      chk("clr_b_ready", 32'(b_ready), 32'(0));
      chk("clr_init_pre", 32'(init_done), 32'(0));
      tick();
      chk("clr_ctrl", 32'(reg_write_control), 32'(1));
      chk("clr_addr", 32'(reg_write), 32'(i));
      chk("clr_data", reg_write_data, 32'(0));
      chk("clr_init_post", 32'(init_done), 32'(i == 31));
    end
  endtask

  // Drive one table row, check readies, push the expected write, then check it.
  task automatic apply(input vec_t v);
    wr_t e;
    wr_t got;
    a_valid = v.av; a_addr = v.aa; a_data = v.ad;
    b_valid = v.bv; b_addr = v.ba; b_data = v.bd;
    #1;
    chk("a_ready", 32'(a_ready), 32'(v.exp_a_ready));
    chk("b_ready", 32'(b_ready), 32'(v.exp_b_ready));
    chk("run_init_done", 32'(init_done), 32'(1));
    e.ctrl = 1'b0; e.addr = last_addr; e.data = last_data; e.chk_payload = 1'b1;
    if (v.exp_a_ready || v.exp_b_ready) begin
      e.addr = v.exp_a_ready ? v.aa : v.ba;
      e.data = v.exp_a_ready ? v.ad : v.bd;
      e.ctrl = (e.addr != '0);
      e.chk_payload = e.ctrl;
      if (e.ctrl) begin
        last_addr = e.addr;
        last_data = e.data;
      end
    end
    sbq.push_back(e);
    tick();
    got = sbq.pop_front();
    chk("wr_ctrl", 32'(reg_write_control), 32'(got.ctrl));
    if (got.chk_payload) begin
      chk("wr_addr", 32'(reg_write), 32'(got.addr));
      chk("wr_data", reg_write_data, got.data);
    end
  endtask

  initial begin
    tbl[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0};
    tbl[1]  = '{1'b1, 5'd5, 32'h0000_00AA, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0};
    tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd4, 32'h0000_0044, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd4, 32'h0000_0044, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd4, 32'h0000_0044, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd4, 32'h0000_0044, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h0000_0077, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd4, 32'h0000_0044, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0};

    // Outputs held at zero during reset, even with a request pending.
    a_valid = 1'b1;
    tick();
    chk_reset_outputs();
    tick();
    a_valid = 1'b0;
    rst = 1'b0;
    clear_seq(31);
    last_addr = 5'd31;
    last_data = '0;

    for (int i = 0; i < 11; i++) begin
      apply(tbl[i]);
    end

    // Reset during RUN takes effect without a clock edge.
    a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h66;
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    tick();
    a_valid = 1'b0;
    rst = 1'b0;
    clear_seq(10);

    // Abort at clear address 10, then restart from 1 with A already waiting.
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    tick();
    rst = 1'b0;
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h0000_0099;
    clear_seq(31);
    chk("first_run_a_ready", 32'(a_ready), 32'(1));
    chk("first_run_b_ready", 32'(b_ready), 32'(0));
    tick();
    a_valid = 1'b0;
    chk("late_ctrl", 32'(reg_write_control), 32'(1));
    chk("late_addr", 32'(reg_write), 32'(9));
    chk("late_data", reg_write_data, 32'h0000_0099);
    tick();
    chk("idle_ctrl", 32'(reg_write_control), 32'(0));
    chk("idle_hold_addr", 32'(reg_write), 32'(9));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter REG_ADDR, default 5, giving the register address width.
REQ-002 The block SHALL have parameter REG_DATA, default 32, giving the register data width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all flops use its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port a_valid, input, 1 bit: requester A (ALU writeback) has a write pending.
REQ-006 The block SHALL have ports a_addr, input, REG_ADDR bits, and a_data, input, REG_DATA bits: requester A destination and value.
REQ-007 The block SHALL have port a_ready, output, 1 bit: requester A's write is accepted this cycle.
REQ-008 The block SHALL have ports b_valid, b_addr, b_data and b_ready, with the same widths and meanings, for requester B (load writeback).
REQ-009 The block SHALL have port reg_write, output, REG_ADDR bits: register file write address.
REQ-010 The block SHALL have port reg_write_data, output, REG_DATA bits: register file write data.
REQ-011 The block SHALL have port reg_write_control, output, 1 bit: register file write enable.
REQ-012 The block SHALL have port init_done, output, 1 bit: the clear sequence is complete and requests are being served.

Function
REQ-013 The FSM SHALL have two states: CLEAR and RUN.
REQ-014 In CLEAR, on each clock edge the block SHALL register reg_write_control=1, reg_write=clear_ptr, reg_write_data=0, then increment clear_ptr.
REQ-015 clear_ptr SHALL start at 1; after address 2**REG_ADDR-1 is issued, the FSM SHALL enter RUN. This gives 31 clear writes at the defaults, and x0 is never written.
REQ-016 In CLEAR, a_ready, b_ready and init_done SHALL be 0.
REQ-017 In RUN, init_done SHALL be 1, and a_ready/b_ready SHALL be combinational functions of state, the valids and last_grant.
REQ-018 In RUN, when only one requester is valid, that requester SHALL get ready=1.
REQ-019 In RUN, when both requesters are valid, the block SHALL grant the requester not granted last (round-robin) and give the other ready=0.
REQ-020 At most one of a_ready and b_ready SHALL be 1 in any cycle, and ready SHALL never be 1 while the matching valid is 0.
REQ-021 last_grant SHALL update only on an accepted transfer (valid && ready).
REQ-022 An accepted transfer in cycle N SHALL appear on reg_write/reg_write_data with reg_write_control=1 in cycle N+1, giving one cycle of latency.
REQ-023 An accepted transfer with addr==0 SHALL complete the handshake and update last_grant, but SHALL produce reg_write_control=0 in cycle N+1.
REQ-024 In a RUN cycle with no accepted transfer, reg_write_control SHALL be 0 in the next cycle, and reg_write/reg_write_data SHALL hold their previous values.
REQ-025 A requester SHALL hold valid, addr and data stable until ready; the block is not required to tolerate violations of this rule.
REQ-026 Throughput SHALL be one write per cycle with continuous valids.

Reset
REQ-027 While rst=1, the outputs SHALL be reg_write_control=0, reg_write=0, reg_write_data=0, init_done=0, a_ready=0, b_ready=0.
REQ-028 While rst=1, the internal state SHALL be state=CLEAR, clear_ptr=1, and last_grant=B, so that A wins the first tie.
REQ-029 Assertion of rst during RUN or mid-CLEAR SHALL immediately abort operation, discard any registered write, and restart the clear sequence from address 1 after release.

Structure
REQ-030 REG_ADDR, REG_DATA, the state enum {CLEAR, RUN} and the requester-id enum {REQ_A, REQ_B} SHALL live in package regfile_pkg.
REQ-031 The two-input round-robin grant logic, including last_grant, SHALL be sub-module rr_arbiter2 (inputs req[1:0] and accept; output gnt[1:0]).
REQ-032 The implementation SHALL be synthesizable, with no latches and no combinational path from reg_write* to the ready outputs.

Verification
REQ-033 Release reset with idle requesters -> addresses 1..31 are written with 0 in 31 consecutive cycles, address 0 is never written, then init_done=1.
REQ-034 In RUN, a_valid=1, a_addr=5, a_data=0x0000_00AA for one cycle -> a_ready=1 that cycle; the next cycle shows reg_write=5, data=0xAA, reg_write_control=1.
REQ-035 Both valid continuously for 4 cycles (A: addr 3; B: addr 4) -> grant order A, B, A, B, with one write per cycle.
REQ-036 b_valid=1, b_addr=0, b_data=0xFFFF_FFFF -> b_ready=1, next-cycle reg_write_control=0, and a subsequent tie grants A.
REQ-037 Assert rst at clear address 10, then release -> outputs go to zero immediately and clearing restarts at address 1 with 31 full writes.
REQ-038 a_valid asserted during CLEAR -> a_ready stays 0 until the first RUN cycle, then the request is accepted that cycle.
